// File: rtl/servo_bank_tester.sv
// Multi-channel hobby-servo PWM tester: one shared frame timer, per-channel
// saturating pulse-width control and an auto-sweep mode for the selected channel.
module servo_bank_tester #(
  parameter int CLK_F          = 100,
  parameter int CHANNELS       = 4,
  parameter int PERIOD_US      = 20000,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int INIT_US        = 1500,
  parameter int STEP_US        = 100,
  parameter int SWEEP_STEP_US  = 10,
  localparam int SEL_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                up_pulse,
  input  logic                dn_pulse,
  input  logic                sel_pulse,
  input  logic                mode_pulse,
  output logic [CHANNELS-1:0] CONTROL_PINS,
  output logic [SEL_W-1:0]    sel_ch,
  output logic                sweep_active,
  output logic [15:0]         pulse_len_out
);
  localparam int PRE_W = (CLK_F > 1) ? $clog2(CLK_F) : 1;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [15:0]         us_cnt_q, us_cnt_d;
  logic [15:0]         work_q [CHANNELS];
  logic [15:0]         work_d [CHANNELS];
  logic [15:0]         shad_q [CHANNELS];
  logic [15:0]         shad_d [CHANNELS];
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                sweep_q, sweep_d;
  logic                dir_dn_q, dir_dn_d;
  logic [CHANNELS-1:0] pins_q, pins_d;
  logic [15:0]         plen_q, plen_d;
  logic                us_tick, frame_end;
  logic [16:0]         cur, up_step, up_swp;
  logic signed [16:0]  dn_step, dn_swp;

  // Next-state logic: shared timebase, manual control decode and sweep stepping.
  always_comb begin
    us_tick   = (pre_q == PRE_W'(CLK_F - 1));
    frame_end = us_tick && (us_cnt_q == 16'(PERIOD_US - 1));
    pre_d     = us_tick ? '0 : pre_q + PRE_W'(1);
    if (frame_end) begin
      us_cnt_d = 16'd0;
    end else if (us_tick) begin
      us_cnt_d = us_cnt_q + 16'd1;
    end else begin
      us_cnt_d = us_cnt_q;
    end

    // 17-bit arithmetic keeps the saturation compares free of wrap-around.
    cur     = {1'b0, work_q[sel_q]};
    up_step = cur + 17'(STEP_US);
    up_swp  = cur + 17'(SWEEP_STEP_US);
    dn_step = $signed(cur) - $signed(17'(STEP_US));
    dn_swp  = $signed(cur) - $signed(17'(SWEEP_STEP_US));

    work_d   = work_q;
    shad_d   = shad_q;
    sel_d    = sel_q;
    dir_dn_d = dir_dn_q;
    sweep_d  = mode_pulse ? !sweep_q : sweep_q;
    if (frame_end) begin
      shad_d = work_q;
    end else begin
      shad_d = shad_q;
    end

    if (sweep_q) begin
      if (!frame_end) begin
        work_d = work_q;
      end else if (!dir_dn_q) begin
        if (up_swp >= 17'(MAX_US)) begin
          work_d[sel_q] = 16'(MAX_US);
          dir_dn_d      = 1'b1;
        end else begin
          work_d[sel_q] = up_swp[15:0];
        end
      end else begin
        if (dn_swp <= $signed(17'(MIN_US))) begin
          work_d[sel_q] = 16'(MIN_US);
          dir_dn_d      = 1'b0;
        end else begin
          work_d[sel_q] = dn_swp[15:0];
        end
      end
    end else begin
      dir_dn_d = mode_pulse ? 1'b0 : dir_dn_q;
      if (up_pulse && !dn_pulse) begin
        work_d[sel_q] = (up_step >= 17'(MAX_US)) ? 16'(MAX_US) : up_step[15:0];
      end else if (dn_pulse && !up_pulse) begin
        work_d[sel_q] = (dn_step <= $signed(17'(MIN_US))) ? 16'(MIN_US) : dn_step[15:0];
      end else begin
        work_d = work_q;
      end
      if (sel_pulse) begin
        sel_d = (sel_q == SEL_W'(CHANNELS - 1)) ? '0 : sel_q + SEL_W'(1);
      end else begin
        sel_d = sel_q;
      end
    end

    plen_d = work_d[sel_d];
    for (int i = 0; i < CHANNELS; i++) begin
      pins_d[i] = (us_cnt_q < shad_q[i]);
    end
  end

  // State registers; reset restarts the frame and restores every channel.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q    <= '0;
      us_cnt_q <= 16'd0;
      work_q   <= '{default: 16'(INIT_US)};
      shad_q   <= '{default: 16'(INIT_US)};
      sel_q    <= '0;
      sweep_q  <= 1'b0;
      dir_dn_q <= 1'b0;
      pins_q   <= '0;
      plen_q   <= 16'(INIT_US);
    end else begin
      pre_q    <= pre_d;
      us_cnt_q <= us_cnt_d;
      work_q   <= work_d;
      shad_q   <= shad_d;
      sel_q    <= sel_d;
      sweep_q  <= sweep_d;
      dir_dn_q <= dir_dn_d;
      pins_q   <= pins_d;
      plen_q   <= plen_d;
    end
  end

  assign CONTROL_PINS  = pins_q;
  assign sel_ch        = sel_q;
  assign sweep_active  = sweep_q;
  assign pulse_len_out = plen_q;

endmodule

// File: doc/servo_bank_tester.md
# servo_bank_tester

Multi-channel successor to the single-servo tester: drives `CHANNELS` hobby-servo PWM outputs from one shared frame timer. Pulse widths are adjustable per channel with saturating limits, and an optional auto-sweep mode exercises the selected channel. The block sits between the debounced front-panel button pulses (one debouncer `trans_up` per button) and the servo connector pins.

## Interface

Parameters:
- `CLK_F`, 100: clock frequency in MHz; clock cycles per microsecond.
- `CHANNELS`, 4: number of servo outputs, 1..16.
- `PERIOD_US`, 20000: PWM frame length in µs, less than 65536.
- `MIN_US`, 1000: lower pulse-width limit in µs.
- `MAX_US`, 2000: upper pulse-width limit; requires `MAX_US < PERIOD_US` and `MAX_US + STEP_US < 65536`.
- `INIT_US`, 1500: reset pulse width for every channel; must lie within `MIN_US..MAX_US`.
- `STEP_US`, 100: manual adjustment step in µs.
- `SWEEP_STEP_US`, 10: sweep increment per frame in µs.

Ports:
- `CLK`, input, 1: system clock.
- `RST`, input, 1: synchronous, active-high reset.
- `up_pulse`, input, 1: one-cycle pulse; increase the selected channel.
- `dn_pulse`, input, 1: one-cycle pulse; decrease the selected channel.
- `sel_pulse`, input, 1: one-cycle pulse; advance the channel select.
- `mode_pulse`, input, 1: one-cycle pulse; toggle sweep mode.
- `CONTROL_PINS`, output, `CHANNELS`: PWM outputs, registered.
- `sel_ch`, output, `max(1,$clog2(CHANNELS))`: currently selected channel.
- `sweep_active`, output, 1: sweep mode is on.
- `pulse_len_out`, output, 16: working pulse width of the selected channel, in µs.

## Operation

- **Prescaler:** `pre` counts 0..`CLK_F-1` and wraps. `us_tick` = (`pre == CLK_F-1`).
- **Frame counter:** `us_cnt` counts 0..`PERIOD_US-1` and advances on `us_tick`. `frame_end` = `us_tick && us_cnt == PERIOD_US-1`.
- **Per-channel state:** each channel has a working register `work[i]` and a shadow register `shad[i]`, both 16 bits. All shadows copy their working values on `frame_end`, so an output never changes width mid-frame.
- **PWM output:** `CONTROL_PINS[i] <= (us_cnt < shad[i])`, registered.
- **Manual mode** (`sweep_active = 0`):
  - `up_pulse`: `work[sel] <= min(work[sel] + STEP_US, MAX_US)`.
  - `dn_pulse`: `work[sel] <= max(work[sel] - STEP_US, MIN_US)`, computed 17-bit signed so there is no wrap.
  - `up_pulse` and `dn_pulse` in the same cycle: no change.
  - `sel_pulse`: `sel_ch <= sel_ch + 1`, wrapping from `CHANNELS-1` to 0.
  - `sel_pulse` together with `up_pulse`/`dn_pulse`: the adjustment applies to the old channel.
- **Sweep mode:**
  - `mode_pulse` in manual mode enters sweep and sets direction to up.
  - `mode_pulse` in sweep returns to manual; `work[sel]` keeps its current value.
  - While sweeping, `up_pulse`, `dn_pulse` and `sel_pulse` are ignored.
  - On each `frame_end`, `work[sel]` moves by `SWEEP_STEP_US`:
    - Direction up: if `work + SWEEP_STEP_US >= MAX_US`, load `MAX_US` and set direction down; otherwise add the step.
    - Direction down: mirror of the above, clamping at `MIN_US` and setting direction up.
  - The shadow load on that same `frame_end` takes the pre-update value, so the new value appears one frame later.
- **Other channels** keep their values at all times, in both modes.

## Timing

- **Reset** (synchronous; takes effect on the edge where `RST` = 1):
  - `pre = 0`, `us_cnt = 0`.
  - All `work` and `shad` = `INIT_US`.
  - `sel_ch = 0`, `sweep_active = 0`, direction = up.
  - `CONTROL_PINS = 0`, `pulse_len_out = INIT_US`.
- **First frame:** on the first edge after `RST` falls, `CONTROL_PINS[i]` rises. The high time is exactly `shad[i]*CLK_F` cycles.
- **Period:** exactly `PERIOD_US*CLK_F` cycles between rising edges.
- **Control latency:** one cycle from a control pulse to `work`, `sel_ch`, `sweep_active` and `pulse_len_out`.
- **Output latency:** a change reaches `CONTROL_PINS` at the first frame start after the next `frame_end`.
- **Reset mid-frame:** all outputs drop on the next edge; the frame restarts from 0.
- **Reset priority:** reset overrides all control pulses in the same cycle.

## Test plan

Bench parameters: `CLK_F`=2, `CHANNELS`=3, `PERIOD_US`=3000, `MIN_US`=1000, `MAX_US`=2000, `INIT_US`=1500, `STEP_US`=100, `SWEEP_STEP_US`=250.

- **Reset and steady state:** reset, then idle 2 frames.
  - Every pin is high for 3000 cycles, low for 3000 cycles, period 6000.
  - `pulse_len_out`=1500, `sel_ch`=0.
- **Saturation:** 6× `up_pulse` on channel 0.
  - `pulse_len_out` goes 1600..2000 and holds at 2000.
  - The next full frame shows a 4000-cycle high on pin 0; pins 1 and 2 stay at 3000.
  - 12× `dn_pulse` then clamps at 1000.
- **Frame-boundary glitch-free update:** `up_pulse` mid-high-phase of frame N.
  - Frame N width is unchanged at 3000 cycles.
  - Frame N+1 width is 3200 cycles.
- **Select wrap and simultaneous events:**
  - 3× `sel_pulse` returns `sel_ch` to 0.
  - `up_pulse` + `dn_pulse` in the same cycle: no change.
  - `sel_pulse` + `up_pulse` in the same cycle: the old channel becomes 1600 and `sel_ch` advances.
- **Sweep:** `mode_pulse` on channel 1.
  - Per frame `work` goes 1750, 2000 (direction flips), 1750, 1500, 1250, 1000 (direction flips), 1250.
  - `up_pulse` and `sel_pulse` during sweep are ignored.
  - A second `mode_pulse` freezes the value.
- **Reset mid-operation:** assert `RST` mid-sweep, mid-frame.
  - Next edge: all pins 0, `sweep_active`=0, all channels 1500.
  - Normal frames resume after release.
